mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 8-bit data memory between the CPU datapath and a
// host loader/debug port. One grant per cycle, round-robin between the ports,
// with a bounded host burst lock. Read data is registered back to the winner.
module mem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_lock,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   localparam int            BW        = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [0:0]    LAST_CPU  = 1'b0;
   localparam logic [0:0]    LAST_HOST = 1'b1;

   logic [0:0]    r_last;
   logic [BW-1:0] r_burst_cnt;
   logic          r_cpu_rvalid;
   logic          r_host_rvalid;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_host_rdata;
   logic          w_lock_cont;
   logic          w_cpu_gnt;
   logic          w_host_gnt;

   // Grant decision: a lone requester always wins; under contention the host
   // keeps a locked burst until the limit, otherwise the ports alternate.
   always_comb begin
      w_lock_cont = (r_last == LAST_HOST) && host_lock && (r_burst_cnt < BURST_MAX);
      w_cpu_gnt   = 1'b0;
      w_host_gnt  = 1'b0;
      if (cpu_req && host_req) begin
         if ((r_last == LAST_HOST) && !w_lock_cont) begin
            w_cpu_gnt = 1'b1;
         end else begin
            w_host_gnt = 1'b1;
         end
      end else begin
         w_cpu_gnt  = cpu_req;
         w_host_gnt = host_req;
      end
   end

   // Memory port mux: idle cycles drive zeros so mem_we can never fire ungranted.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (w_cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
      end else if (w_host_gnt) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_we    = host_we;
      end
   end

   // Arbitration history: last winner and saturating host burst length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last      <= LAST_HOST;
         r_burst_cnt <= '0;
      end else if (w_cpu_gnt) begin
         r_last      <= LAST_CPU;
         r_burst_cnt <= '0;
      end else if (w_host_gnt) begin
         r_last <= LAST_HOST;
         if (r_burst_cnt < BURST_MAX) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
         end
      end else begin
         r_burst_cnt <= '0;
      end
   end

   // Read return: capture memory data for a granted read, pulse rvalid once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rvalid  <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_cpu_rdata   <= '0;
         r_host_rdata  <= '0;
      end else begin
         r_cpu_rvalid  <= w_cpu_gnt && !cpu_we;
         r_host_rvalid <= w_host_gnt && !host_we;
         if (w_cpu_gnt && !cpu_we) begin
            r_cpu_rdata <= mem_rdata;
         end
         if (w_host_gnt && !host_we) begin
            r_host_rdata <= mem_rdata;
         end
      end
   end

   assign cpu_gnt     = w_cpu_gnt;
   assign host_gnt    = w_host_gnt;
   assign cpu_stall   = cpu_req && !w_cpu_gnt;
   assign cpu_rvalid  = r_cpu_rvalid;
   assign cpu_rdata   = r_cpu_rdata;
   assign host_rvalid = r_host_rvalid;
   assign host_rdata  = r_host_rdata;

endmodule
